// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the execute stage.
//   - ALU opcode encodings (ALU_ADD .. ALU_LUI; 4'hE/4'hF are illegal)
//   - ex_state_e: iterative-unit sequencing states (IDLE/BUSY/DONE)
//   - REG_ZERO: architectural zero register number
package mips_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_MUL  = 4'hA;
    localparam logic [3:0] ALU_DIVU = 4'hB;
    localparam logic [3:0] ALU_REMU = 4'hC;
    localparam logic [3:0] ALU_LUI  = 4'hD;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: iterative unsigned multiply / divide, one step per cycle.
//   MUL  : WIDTH-step shift-add, low WIDTH bits of the product.
//   DIVU : WIDTH-step restoring divide, quotient.
//   REMU : same divide, remainder. Divide by zero naturally yields
//          quotient = all ones, remainder = dividend.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   start           load op/operands and begin iterating (ignored while kill)
//   kill            abandon any iteration in progress
//   op, a, b        operation and operands, sampled on start
//   busy            an iteration step happens this cycle
//   last            this cycle performs the final step
//   result          valid the cycle after last, held until next start
module mul_div_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             kill,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // acc: product accumulator (MUL) or partial remainder (DIVU/REMU)
    // opa: shifting multiplicand (MUL) or dividend-in / quotient-out (DIV)
    // opb: shifting multiplier (MUL) or divisor (DIV)
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   div_r;

    assign busy = busy_q;
    assign last = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        acc_d  = acc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        // Partial remainder shifted left with the next dividend bit.
        div_r  = {acc_q, opa_q[WIDTH-1]};
        if (kill) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            op_d   = op;
            acc_d  = '0;
            opa_d  = a;
            opb_d  = b;
        end else if (busy_q) begin
            if (op_q == ALU_MUL) begin
                if (opb_q[0]) begin
                    acc_d = acc_q + opa_q;
                end
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end else begin
                if (div_r >= {1'b0, opb_q}) begin
                    acc_d = WIDTH'(div_r - {1'b0, opb_q});
                    opa_d = {opa_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_r[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end
            end
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            acc_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            acc_q  <= acc_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
        end
    end

    assign result = (op_q == ALU_DIVU) ? opa_q : acc_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS-style execute stage feeding the EX/MEM register.
//   Combinational ALU (ops 0-9, D), iterative MUL/DIVU/REMU (A-C) with a
//   stall back to IF/ID/ID_EX, and the registered mem_* outputs.
// Configuration macro: EX_MULDIV_EN
//   defined     : mul_div_iter and the IDLE/BUSY/DONE sequencer are built.
//   not defined : ops A-C produce 0 in one cycle, ex_stall is tied low.
// Handshake: ex_stall high means upstream must hold PC, IF/ID and ID/EX.
//   An instruction in ID/EX is consumed on any edge where ex_stall is low;
//   an iterative op raises ex_stall from its issue cycle until the cycle
//   its result is written, and that final cycle has ex_stall low.
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   ex_*                  ID/EX register contents (operands, dest, controls)
//   ex_flush              kill the current EX instruction
//   ex_stall              combinational stall request
//   mem_*                 EX/MEM register contents
//   dbg_state             sequencer state (always ST_IDLE without EX_MULDIV_EN)
module ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic                  ex_flush,
    input  logic [3:0]            ex_alu_op,
    input  logic [WIDTH-1:0]      ex_rs_val,
    input  logic [WIDTH-1:0]      ex_rt_val,
    input  logic [WIDTH-1:0]      ex_imm,
    input  logic [REG_ADDR_W-1:0] ex_rt_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_reg_dst,
    input  logic                  ex_alu_src,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_mem_wen,
    input  logic                  ex_mem_ren,
    output logic                  ex_stall,
    output logic                  mem_valid,
    output logic [WIDTH-1:0]      mem_alu_result,
    output logic [WIDTH-1:0]      mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_write_reg,
    output logic                  mem_reg_write,
    output logic                  mem_mem_to_reg,
    output logic                  mem_mem_wen,
    output logic                  mem_mem_ren,
    output logic [1:0]            dbg_state
);

    // ---------------- combinational ALU ----------------
    logic [WIDTH-1:0]      op_b;
    logic [4:0]            shamt;
    logic [WIDTH-1:0]      alu_res;
    logic [REG_ADDR_W-1:0] dest;
    logic                  dest_we;
    logic                  issue_live;

    always_comb begin
        op_b    = ex_alu_src ? ex_imm : ex_rt_val;
        shamt   = ex_imm[10:6];
        alu_res = '0;
        case (ex_alu_op)
            ALU_ADD: alu_res = ex_rs_val + op_b;
            ALU_SUB: alu_res = ex_rs_val - op_b;
            ALU_AND: alu_res = ex_rs_val & op_b;
            ALU_OR:  alu_res = ex_rs_val | op_b;
            ALU_XOR: alu_res = ex_rs_val ^ op_b;
            ALU_NOR: alu_res = ~(ex_rs_val | op_b);
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(ex_rs_val) < $signed(op_b))};
            ALU_SLL: alu_res = ex_rt_val << shamt;
            ALU_SRL: alu_res = ex_rt_val >> shamt;
            ALU_SRA: alu_res = $unsigned($signed(ex_rt_val) >>> shamt);
            ALU_LUI: alu_res = WIDTH'(ex_imm[15:0]) << 16;
            // MUL/DIVU/REMU never write through this path when the
            // iterative unit exists; illegal ops also give 0.
            default: alu_res = '0;
        endcase
        dest       = ex_reg_dst ? ex_rd_addr : ex_rt_addr;
        dest_we    = ex_reg_write && (dest != REG_ADDR_W'(REG_ZERO));
        issue_live = ex_valid && !ex_flush;
    end

    // ---------------- EX/MEM register next values ----------------
    logic                  mem_valid_d, mem_valid_q;
    logic [WIDTH-1:0]      mem_alu_result_d, mem_alu_result_q;
    logic [WIDTH-1:0]      mem_store_data_d, mem_store_data_q;
    logic [REG_ADDR_W-1:0] mem_write_reg_d, mem_write_reg_q;
    logic                  mem_reg_write_d, mem_reg_write_q;
    logic                  mem_mem_to_reg_d, mem_mem_to_reg_q;
    logic                  mem_mem_wen_d, mem_mem_wen_q;
    logic                  mem_mem_ren_d, mem_mem_ren_q;
    logic                  sc_write;
    logic                  stall_req;

`ifdef EX_MULDIV_EN
    ex_state_e             state_q, state_d;
    logic                  is_iter;
    logic                  iter_start;
    logic                  iter_busy;
    logic                  iter_last;
    logic [WIDTH-1:0]      iter_result;
    // Destination and controls captured at issue so ID/EX may change freely.
    logic [REG_ADDR_W-1:0] lat_dest_q, lat_dest_d;
    logic                  lat_we_q, lat_we_d;
    logic                  lat_m2r_q, lat_m2r_d;
    logic                  lat_wen_q, lat_wen_d;
    logic                  lat_ren_q, lat_ren_d;
    logic [WIDTH-1:0]      lat_store_q, lat_store_d;

    assign is_iter = (ex_alu_op == ALU_MUL) || (ex_alu_op == ALU_DIVU) ||
                     (ex_alu_op == ALU_REMU);

    mul_div_iter #(.WIDTH(WIDTH)) u_mul_div_iter (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (iter_start),
        .kill    (ex_flush),
        .op      (ex_alu_op),
        .a       (ex_rs_val),
        .b       (op_b),
        .busy    (iter_busy),
        .last    (iter_last),
        .result  (iter_result)
    );
`endif

    always_comb begin
        sc_write         = 1'b0;
        stall_req        = 1'b0;
        mem_valid_d      = 1'b0;
        mem_alu_result_d = alu_res;
        mem_store_data_d = ex_rt_val;
        mem_write_reg_d  = dest;
        mem_reg_write_d  = 1'b0;
        mem_mem_to_reg_d = 1'b0;
        mem_mem_wen_d    = 1'b0;
        mem_mem_ren_d    = 1'b0;
`ifdef EX_MULDIV_EN
        state_d     = state_q;
        iter_start  = 1'b0;
        lat_dest_d  = lat_dest_q;
        lat_we_d    = lat_we_q;
        lat_m2r_d   = lat_m2r_q;
        lat_wen_d   = lat_wen_q;
        lat_ren_d   = lat_ren_q;
        lat_store_d = lat_store_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_live && is_iter) begin
                    iter_start  = 1'b1;
                    stall_req   = 1'b1;
                    state_d     = ST_BUSY;
                    lat_dest_d  = dest;
                    lat_we_d    = dest_we;
                    lat_m2r_d   = ex_mem_to_reg;
                    lat_wen_d   = ex_mem_wen;
                    lat_ren_d   = ex_mem_ren;
                    lat_store_d = ex_rt_val;
                end else begin
                    sc_write = issue_live;
                end
            end
            ST_BUSY: begin
                if (ex_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_req = 1'b1;
                    if (iter_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!ex_flush) begin
                    mem_valid_d      = 1'b1;
                    mem_alu_result_d = iter_result;
                    mem_store_data_d = lat_store_q;
                    mem_write_reg_d  = lat_dest_q;
                    mem_reg_write_d  = lat_we_q;
                    mem_mem_to_reg_d = lat_m2r_q;
                    mem_mem_wen_d    = lat_wen_q;
                    mem_mem_ren_d    = lat_ren_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`else
        sc_write = issue_live;
`endif
        if (sc_write) begin
            mem_valid_d      = 1'b1;
            mem_reg_write_d  = dest_we;
            mem_mem_to_reg_d = ex_mem_to_reg;
            mem_mem_wen_d    = ex_mem_wen;
            mem_mem_ren_d    = ex_mem_ren;
        end
    end

    // Reset overrides any issue-cycle stall request combinationally.
    assign ex_stall = stall_req && reset_n;

`ifdef EX_MULDIV_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lat_dest_q  <= '0;
            lat_we_q    <= 1'b0;
            lat_m2r_q   <= 1'b0;
            lat_wen_q   <= 1'b0;
            lat_ren_q   <= 1'b0;
            lat_store_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_dest_q  <= lat_dest_d;
            lat_we_q    <= lat_we_d;
            lat_m2r_q   <= lat_m2r_d;
            lat_wen_q   <= lat_wen_d;
            lat_ren_q   <= lat_ren_d;
            lat_store_q <= lat_store_d;
        end
    end

    assign dbg_state = state_q;
`else
    assign dbg_state = ST_IDLE;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid_q      <= 1'b0;
            mem_alu_result_q <= '0;
            mem_store_data_q <= '0;
            mem_write_reg_q  <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_mem_wen_q    <= 1'b0;
            mem_mem_ren_q    <= 1'b0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_store_data_q <= mem_store_data_d;
            mem_write_reg_q  <= mem_write_reg_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            mem_mem_wen_q    <= mem_mem_wen_d;
            mem_mem_ren_q    <= mem_mem_ren_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_store_data = mem_store_data_q;
    assign mem_write_reg  = mem_write_reg_q;
    assign mem_reg_write  = mem_reg_write_q;
    assign mem_mem_to_reg = mem_mem_to_reg_q;
    assign mem_mem_wen    = mem_mem_wen_q;
    assign mem_mem_ren    = mem_mem_ren_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage. Expectations follow the build:
// with EX_MULDIV_EN the iterative ops stall WIDTH+1 cycles, otherwise they
// return 0 in one cycle with no stall.
module tb_ex_stage;
    import mips_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clock;
    logic          reset_n;
    logic          ex_valid, ex_flush;
    logic [3:0]    ex_alu_op;
    logic [W-1:0]  ex_rs_val, ex_rt_val, ex_imm;
    logic [AW-1:0] ex_rt_addr, ex_rd_addr;
    logic          ex_reg_dst, ex_alu_src, ex_reg_write, ex_mem_to_reg, ex_mem_wen, ex_mem_ren;
    logic          ex_stall, mem_valid;
    logic [W-1:0]  mem_alu_result, mem_store_data;
    logic [AW-1:0] mem_write_reg;
    logic          mem_reg_write, mem_mem_to_reg, mem_mem_wen, mem_mem_ren;
    logic [1:0]    dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    ex_stage #(.WIDTH(W), .REG_ADDR_W(AW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ex_valid       (ex_valid),
        .ex_flush       (ex_flush),
        .ex_alu_op      (ex_alu_op),
        .ex_rs_val      (ex_rs_val),
        .ex_rt_val      (ex_rt_val),
        .ex_imm         (ex_imm),
        .ex_rt_addr     (ex_rt_addr),
        .ex_rd_addr     (ex_rd_addr),
        .ex_reg_dst     (ex_reg_dst),
        .ex_alu_src     (ex_alu_src),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_mem_wen     (ex_mem_wen),
        .ex_mem_ren     (ex_mem_ren),
        .ex_stall       (ex_stall),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_write_reg  (mem_write_reg),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_mem_wen    (mem_mem_wen),
        .mem_mem_ren    (mem_mem_ren),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        ex_valid      = 1'b0;
        ex_flush      = 1'b0;
        ex_alu_op     = ALU_ADD;
        ex_rs_val     = '0;
        ex_rt_val     = '0;
        ex_imm        = '0;
        ex_rt_addr    = 5'd9;
        ex_rd_addr    = '0;
        ex_reg_dst    = 1'b1;
        ex_alu_src    = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
        ex_mem_wen    = 1'b0;
        ex_mem_ren    = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd);
        drive_idle();
        ex_valid     = 1'b1;
        ex_alu_op    = op;
        ex_rs_val    = rs;
        ex_rt_val    = rt;
        ex_imm       = imm;
        ex_alu_src   = src;
        ex_rd_addr   = rd;
        ex_reg_write = 1'b1;
    endtask

    // Counts stall cycles (bounded), optionally scrambling ID/EX operand
    // fields each cycle, and records whether mem_valid stayed low.
    task automatic wait_stall(input bit scramble, output int cycles, output bit bubbles_ok);
        cycles     = 0;
        bubbles_ok = 1'b1;
        while (ex_stall && cycles < 100) begin
            cycles++;
            @(posedge clock);
            #1;
            if (scramble) begin
                ex_rs_val  = $urandom;
                ex_rt_val  = $urandom;
                ex_imm     = $urandom;
                ex_rd_addr = 5'($urandom_range(1, 31));
            end
            if (mem_valid !== 1'b0) bubbles_ok = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  cyc;
        bit  bub;

        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset mem_valid", 32'(mem_valid), 32'd0);
        check("reset result", mem_alu_result, 32'd0);
        check("reset stall", 32'(ex_stall), 32'd0);
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        tick();

        // ADD overflow wraps, no stall
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd3);
        #1;
        check("add stall", 32'(ex_stall), 32'd0);
        tick();
        check("add result", mem_alu_result, 32'h8000_0000);
        check("add valid", 32'(mem_valid), 32'd1);
        check("add dest", 32'(mem_write_reg), 32'd3);
        check("add reg_write", 32'(mem_reg_write), 32'd1);
        check("add store_data", mem_store_data, 32'h1);

        issue(ALU_SUB, 32'd5, 32'd7, 32'h0, 1'b0, 5'd4);
        tick();
        check("sub result", mem_alu_result, 32'hFFFF_FFFE);

        // SLT signed with immediate operand
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b1, 5'd4);
        tick();
        check("slt result", mem_alu_result, 32'd1);
        check("slt reg_write", 32'(mem_reg_write), 32'd1);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b1, 5'd0);
        tick();
        check("slt r0 result", mem_alu_result, 32'd1);
        check("slt r0 reg_write", 32'(mem_reg_write), 32'd0);
        check("slt r0 valid", 32'(mem_valid), 32'd1);

        // shifts: shamt in imm[10:6] = 4
        issue(ALU_SRA, 32'h0, 32'h8000_0000, 32'h100, 1'b0, 5'd5);
        tick();
        check("sra result", mem_alu_result, 32'hF800_0000);
        issue(ALU_SRL, 32'h0, 32'h8000_0000, 32'h100, 1'b0, 5'd5);
        tick();
        check("srl result", mem_alu_result, 32'h0800_0000);
        issue(ALU_SLL, 32'h0, 32'h0000_000F, 32'h100, 1'b0, 5'd5);
        tick();
        check("sll result", mem_alu_result, 32'h0000_00F0);

        issue(ALU_NOR, 32'h0F0F_0000, 32'h0000_00FF, 32'h0, 1'b0, 5'd6);
        tick();
        check("nor result", mem_alu_result, 32'hF0F0_FF00);
        issue(ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 1'b0, 5'd6);
        tick();
        check("xor result", mem_alu_result, 32'hF0F0_F0F0);

        // LUI with RegDst=0: destination is rt
        issue(ALU_LUI, 32'h0, 32'h0, 32'hFFFF_1234, 1'b1, 5'd7);
        ex_reg_dst = 1'b0;
        tick();
        check("lui result", mem_alu_result, 32'h1234_0000);
        check("lui dest rt", 32'(mem_write_reg), 32'd9);

        // illegal op: result 0, controls forwarded
        issue(4'hE, 32'h1234, 32'h5678, 32'h0, 1'b0, 5'd8);
        ex_mem_wen = 1'b1;
        tick();
        check("illegal result", mem_alu_result, 32'd0);
        check("illegal wen", 32'(mem_mem_wen), 32'd1);
        check("illegal store", mem_store_data, 32'h5678);

        // bubble
        drive_idle();
        tick();
        check("bubble valid", 32'(mem_valid), 32'd0);
        check("bubble wen", 32'(mem_mem_wen), 32'd0);

        // flush of a single-cycle op
        issue(ALU_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 5'd3);
        ex_mem_ren = 1'b1;
        ex_flush   = 1'b1;
        tick();
        check("flush sc valid", 32'(mem_valid), 32'd0);
        check("flush sc reg_write", 32'(mem_reg_write), 32'd0);
        check("flush sc ren", 32'(mem_mem_ren), 32'd0);

`ifdef EX_MULDIV_EN
        // MUL 7*6
        issue(ALU_MUL, 32'd7, 32'd6, 32'h0, 1'b0, 5'd10);
        #1;
        wait_stall(1'b0, cyc, bub);
        check("mul stall cycles", 32'(cyc), 32'd33);
        check("mul bubbles", 32'(bub), 32'd1);
        check("mul done state", 32'(dbg_state), 32'(ST_DONE));
        tick();
        check("mul result", mem_alu_result, 32'd42);
        check("mul valid", 32'(mem_valid), 32'd1);
        check("mul dest", 32'(mem_write_reg), 32'd10);
        drive_idle();

        // DIVU by zero with ID/EX scrambled during BUSY
        issue(ALU_DIVU, 32'd100, 32'd0, 32'h0, 1'b0, 5'd11);
        #1;
        wait_stall(1'b1, cyc, bub);
        check("divu0 stall cycles", 32'(cyc), 32'd33);
        tick();
        check("divu0 result", mem_alu_result, 32'hFFFF_FFFF);
        check("divu0 dest", 32'(mem_write_reg), 32'd11);
        drive_idle();

        issue(ALU_REMU, 32'd100, 32'd7, 32'h0, 1'b0, 5'd12);
        #1;
        wait_stall(1'b1, cyc, bub);
        tick();
        check("remu result", mem_alu_result, 32'd2);
        check("remu store", mem_store_data, 32'd7);
        drive_idle();

        issue(ALU_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 5'd12);
        #1;
        wait_stall(1'b1, cyc, bub);
        tick();
        check("divu result", mem_alu_result, 32'd14);
        drive_idle();

        // flush at BUSY cycle 10 of a DIVU
        issue(ALU_DIVU, 32'd1000, 32'd3, 32'h0, 1'b0, 5'd13);
        repeat (10) tick();
        check("pre-flush state", 32'(dbg_state), 32'(ST_BUSY));
        ex_flush = 1'b1;
        #1;
        check("flush stall drop", 32'(ex_stall), 32'd0);
        tick();
        drive_idle();
        #1;
        check("flush valid", 32'(mem_valid), 32'd0);
        check("flush state", 32'(dbg_state), 32'(ST_IDLE));
        check("flush stall", 32'(ex_stall), 32'd0);
        issue(ALU_ADD, 32'd2, 32'd3, 32'h0, 1'b0, 5'd14);
        #1;
        check("post-flush add stall", 32'(ex_stall), 32'd0);
        tick();
        check("post-flush add", mem_alu_result, 32'd5);
        check("post-flush valid", 32'(mem_valid), 32'd1);

        // reset mid-MUL
        issue(ALU_MUL, 32'd9, 32'd9, 32'h0, 1'b0, 5'd15);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("midreset result", mem_alu_result, 32'd0);
        check("midreset valid", 32'(mem_valid), 32'd0);
        check("midreset stall", 32'(ex_stall), 32'd0);
        check("midreset state", 32'(dbg_state), 32'(ST_IDLE));
        drive_idle();
        tick();
        reset_n = 1'b1;
        tick();
        issue(ALU_MUL, 32'd3, 32'd5, 32'h0, 1'b0, 5'd16);
        #1;
        wait_stall(1'b0, cyc, bub);
        check("mul2 stall cycles", 32'(cyc), 32'd33);
        tick();
        check("mul2 result", mem_alu_result, 32'd15);
        check("mul2 valid", 32'(mem_valid), 32'd1);
        drive_idle();
`else
        // iterative ops collapse to single-cycle zero results
        issue(ALU_MUL, 32'd7, 32'd6, 32'h0, 1'b0, 5'd10);
        #1;
        check("mul nostall", 32'(ex_stall), 32'd0);
        tick();
        check("mul zero result", mem_alu_result, 32'd0);
        check("mul valid", 32'(mem_valid), 32'd1);
        check("mul dest", 32'(mem_write_reg), 32'd10);
        issue(ALU_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 5'd11);
        #1;
        check("divu nostall", 32'(ex_stall), 32'd0);
        tick();
        check("divu zero result", mem_alu_result, 32'd0);
        check("state idle", 32'(dbg_state), 32'(ST_IDLE));
        issue(ALU_ADD, 32'd2, 32'd3, 32'h0, 1'b0, 5'd14);
        tick();
        check("add after iter", mem_alu_result, 32'd5);
        issue(ALU_ADD, 32'd9, 32'd9, 32'h0, 1'b0, 5'd15);
        ex_valid = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset result", mem_alu_result, 32'd0);
        check("async reset stall", 32'(ex_stall), 32'd0);
        drive_idle();
        tick();
        reset_n = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
